// File: rtl/matmul_hs.sv
// matmul_hs: handshaked C = A*B (or C += A*B) sequencer
// on one shared word-addressed memory port.
module matmul_hs #(
  parameter int DIM_BITS = 16,
  parameter int MEM_AW   = 16,
  parameter int MEM_DW   = 32,
  parameter int PREC     = 16,
  parameter int ACC_W    = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  input  logic [MEM_AW-1:0]   aBASE,
  input  logic [MEM_AW-1:0]   bBASE,
  input  logic [MEM_AW-1:0]   cBASE,
  input  logic [DIM_BITS-1:0] aROWS,
  input  logic [DIM_BITS-1:0] aCOLS,
  input  logic [DIM_BITS-1:0] bCOLS,
  input  logic [DIM_BITS-1:0] aSTRIDE,
  input  logic [DIM_BITS-1:0] bSTRIDE,
  input  logic [DIM_BITS-1:0] cSTRIDE,
  input  logic                mode_accum,
  input  logic                mode_bt,
  input  logic                signed_en,
  input  logic                sat_en,
  output logic                mem_req,
  output logic                mem_write,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [MEM_DW-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [MEM_DW-1:0]   mem_rdata,
  output logic                busy,
  output logic                ret
);

  typedef enum logic [3:0] {
    IDLE, ROW, COL, RD_C, WT_C, RD_A,
    WT_A, RD_B, WT_B, MAC, WR_C, DONE
  } state_t;

  state_t state, state_n;

  logic [MEM_AW-1:0]   b_base_q;
  logic [DIM_BITS-1:0] rows_q, cols_q, bcols_q;
  logic [DIM_BITS-1:0] astr_q, bstr_q, cstr_q;
  logic                accum_q, bt_q, sgn_q, sat_q;

  logic [DIM_BITS-1:0] i, j, k, i_n, j_n, k_n, k_inc;
  logic [MEM_AW-1:0]   a_row, c_row, b_col;
  logic [MEM_AW-1:0]   a_ptr, b_ptr, c_ptr;
  logic [MEM_AW-1:0]   a_row_n, c_row_n, b_col_n;
  logic [MEM_AW-1:0]   a_ptr_n, b_ptr_n, c_ptr_n;
  logic [ACC_W-1:0]    acc, acc_n;
  logic [PREC-1:0]     a_op, b_op, a_op_n, b_op_n;

  logic [ACC_W-1:0]    a_x, b_x, prod, c_x;
  logic [MEM_AW-1:0]   b_k_step, b_j_step;

  logic                req_n, write_n;
  logic [MEM_AW-1:0]   addr_n;
  logic [MEM_DW-1:0]   wdata_n;

  // Write-back value: clamp to the C range or keep low bits
  function automatic logic [MEM_DW-1:0] wb_val(
    input logic [ACC_W-1:0] v,
    input logic             s,
    input logic             sat
  );
    logic [MEM_DW-1:0] r;
    r = v[MEM_DW-1:0];
    if (sat) begin
      if (s) begin
        if (v[ACC_W-1:MEM_DW-1] !=
            {(ACC_W-MEM_DW+1){v[ACC_W-1]}})
          r = v[ACC_W-1] ?
              {1'b1, {(MEM_DW-1){1'b0}}} :
              {1'b0, {(MEM_DW-1){1'b1}}};
      end else if (|v[ACC_W-1:MEM_DW]) begin
        r = '1;
      end
    end
    return r;
  endfunction

  // Operands are extended to ACC_W, so the low ACC_W
  // product bits equal the full product mod 2^ACC_W.
  assign a_x = {{(ACC_W-PREC){sgn_q & a_op[PREC-1]}}, a_op};
  assign b_x = {{(ACC_W-PREC){sgn_q & b_op[PREC-1]}}, b_op};
  assign prod = a_x * b_x;
  assign c_x = {{(ACC_W-MEM_DW){sgn_q & mem_rdata[MEM_DW-1]}},
                mem_rdata};
  assign k_inc = k + 1'b1;
  assign b_k_step = bt_q ? MEM_AW'(1) : MEM_AW'(bstr_q);
  assign b_j_step = bt_q ? MEM_AW'(bstr_q) : MEM_AW'(1);

  // Latch the job configuration when a start is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_base_q <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
      bcols_q  <= '0;
      astr_q   <= '0;
      bstr_q   <= '0;
      cstr_q   <= '0;
      accum_q  <= 1'b0;
      bt_q     <= 1'b0;
      sgn_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else if (state == IDLE && go) begin
      b_base_q <= bBASE;
      rows_q   <= aROWS;
      cols_q   <= aCOLS;
      bcols_q  <= bCOLS;
      astr_q   <= aSTRIDE;
      bstr_q   <= bSTRIDE;
      cstr_q   <= cSTRIDE;
      accum_q  <= mode_accum;
      bt_q     <= mode_bt;
      sgn_q    <= signed_en;
      sat_q    <= sat_en;
    end
  end

  // Next-state, loop counters, pointers and accumulator
  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    k_n     = k;
    a_row_n = a_row;
    c_row_n = c_row;
    b_col_n = b_col;
    a_ptr_n = a_ptr;
    b_ptr_n = b_ptr;
    c_ptr_n = c_ptr;
    acc_n   = acc;
    a_op_n  = a_op;
    b_op_n  = b_op;
    unique case (state)
      IDLE: if (go) begin
        state_n = ROW;
        i_n     = '0;
        a_row_n = aBASE;
        c_row_n = cBASE;
      end
      ROW: begin
        if (i == rows_q || bcols_q == '0) begin
          state_n = DONE;
        end else begin
          state_n = COL;
          j_n     = '0;
          b_col_n = b_base_q;
          c_ptr_n = c_row;
        end
      end
      COL: begin
        if (j == bcols_q) begin
          state_n = ROW;
          i_n     = i + 1'b1;
          a_row_n = a_row + MEM_AW'(astr_q);
          c_row_n = c_row + MEM_AW'(cstr_q);
        end else begin
          k_n     = '0;
          a_ptr_n = a_row;
          b_ptr_n = b_col;
          if (accum_q) begin
            state_n = RD_C;
          end else begin
            acc_n   = '0;
            state_n = (cols_q == '0) ? WR_C : RD_A;
          end
        end
      end
      RD_C: if (mem_gnt) state_n = WT_C;
      WT_C: if (mem_rvalid) begin
        acc_n   = c_x;
        state_n = (cols_q == '0) ? WR_C : RD_A;
      end
      RD_A: if (mem_gnt) state_n = WT_A;
      WT_A: if (mem_rvalid) begin
        a_op_n  = mem_rdata[PREC-1:0];
        state_n = RD_B;
      end
      RD_B: if (mem_gnt) state_n = WT_B;
      WT_B: if (mem_rvalid) begin
        b_op_n  = mem_rdata[PREC-1:0];
        state_n = MAC;
      end
      MAC: begin
        acc_n   = acc + prod;
        k_n     = k_inc;
        a_ptr_n = a_ptr + 1'b1;
        b_ptr_n = b_ptr + b_k_step;
        state_n = (k_inc == cols_q) ? WR_C : RD_A;
      end
      WR_C: if (mem_gnt) begin
        j_n     = j + 1'b1;
        c_ptr_n = c_ptr + 1'b1;
        b_col_n = b_col + b_j_step;
        state_n = COL;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Memory request fields for the state being entered
  always_comb begin
    req_n   = state_n inside {RD_C, RD_A, RD_B, WR_C};
    write_n = (state_n == WR_C);
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    case (state_n)
      RD_C, WR_C: addr_n = c_ptr_n;
      RD_A:       addr_n = a_ptr_n;
      RD_B:       addr_n = b_ptr_n;
      default:    addr_n = mem_addr;
    endcase
    if (state_n == WR_C)
      wdata_n = wb_val(acc_n, sgn_q, sat_q);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      a_row     <= '0;
      c_row     <= '0;
      b_col     <= '0;
      a_ptr     <= '0;
      b_ptr     <= '0;
      c_ptr     <= '0;
      acc       <= '0;
      a_op      <= '0;
      b_op      <= '0;
      mem_req   <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      ret       <= 1'b0;
    end else begin
      state     <= state_n;
      i         <= i_n;
      j         <= j_n;
      k         <= k_n;
      a_row     <= a_row_n;
      c_row     <= c_row_n;
      b_col     <= b_col_n;
      a_ptr     <= a_ptr_n;
      b_ptr     <= b_ptr_n;
      c_ptr     <= c_ptr_n;
      acc       <= acc_n;
      a_op      <= a_op_n;
      b_op      <= b_op_n;
      mem_req   <= req_n;
      mem_write <= write_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      busy      <= !(state_n inside {IDLE, DONE});
      ret       <= (state_n == DONE);
    end
  end

endmodule

// File: doc/matmul_hs.md
# matmul_hs

Handshaked, parametrised successor to the team's simple matrix-multiply sequencer: computes C = A·B, or C += A·B in accumulate mode, over a single shared word-addressed memory port. It adds request/grant and read-valid handshakes (any memory latency), signed or unsigned operands, a wide internal accumulator with optional saturation, and a transposed-B walk. It sits behind the control register block and in front of the memory arbiter.

## Interface
- DIM_BITS, 16: width of dimension and stride inputs and loop counters
- MEM_AW, 16: memory address width
- MEM_DW, 32: memory data width; C element width
- PREC, 16: operand width, taken from mem_rdata[PREC-1:0]
- ACC_W, 40: accumulator width; must satisfy ACC_W ≥ 2·PREC and ACC_W ≥ MEM_DW
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- go  in  1  start pulse; sampled only in IDLE
- aBASE, bBASE, cBASE  in  MEM_AW  matrix base addresses
- aROWS, aCOLS, bCOLS  in  DIM_BITS  dimensions (A is aROWS×aCOLS, B is aCOLS×bCOLS)
- aSTRIDE, bSTRIDE, cSTRIDE  in  DIM_BITS  row strides in words
- mode_accum  in  1  1: C initialised from memory; 0: C initialised to 0
- mode_bt  in  1  1: B stored transposed (B[k][j] at bBASE + j·bSTRIDE + k)
- signed_en  in  1  operands and C treated as two's complement
- sat_en  in  1  saturate on write-back; 0: truncate
- mem_req  out  1  request valid
- mem_write  out  1  1 write, 0 read
- mem_addr  out  MEM_AW  request address
- mem_wdata  out  MEM_DW  write data
- mem_gnt  in  1  request accepted this cycle when mem_req & mem_gnt
- mem_rvalid  in  1  read data valid; one per accepted read, in order
- mem_rdata  in  MEM_DW  read data
- busy  out  1  high from go acceptance until ret
- ret  out  1  one-cycle completion pulse

## Operation
- All configuration inputs latched in IDLE on go; changes while busy have no effect. go while busy ignored.
- States: IDLE, ROW, COL, RD_C, WT_C, RD_A, WT_A, RD_B, WT_B, MAC, WR_C, DONE.
- IDLE: go → latch, i=0, busy=1 → ROW. ROW: i==aROWS → DONE, else j=0 → COL. COL: j==bCOLS → i+1 → ROW; else k=0 → RD_C if mode_accum, else acc=0 → RD_A.
- RD_x: mem_req=1, mem_write=0, mem_addr held stable until mem_gnt; on grant mem_req drops → WT_x. WT_x: wait for mem_rvalid, capture data.
- WT_C: acc = sign/zero-extended C word (per signed_en) → RD_A, or → WR_C if aCOLS==0.
- RD_A skipped to WR_C when k==aCOLS (aCOLS==0 writes 0, or C unchanged in accum mode).
- WT_B → MAC: acc += a·b, full 2·PREC product signed or unsigned per signed_en, extended to ACC_W, wrap modulo 2^ACC_W; k+1 → RD_A.
- Addresses: A[i][k] = aBASE + i·aSTRIDE + k; B[k][j] = bBASE + k·bSTRIDE + j (mode_bt: bBASE + j·bSTRIDE + k); C[i][j] = cBASE + i·cSTRIDE + j; all computed incrementally, wrap modulo 2^MEM_AW.
- WR_C: mem_req=1, mem_write=1, mem_wdata = sat_en ? clamp(acc) : acc[MEM_DW-1:0]; clamp range [-2^(MEM_DW-1), 2^(MEM_DW-1)-1] signed, [0, 2^MEM_DW-1] unsigned; on grant j+1 → COL.
- DONE: ret=1, busy=0 for one cycle → IDLE.
- At most one outstanding request; mem_rvalid outside WT_x ignored.

## Timing
- Reset values: mem_req=0, mem_write=0, mem_addr=0, mem_wdata=0, busy=0, ret=0; state IDLE; accumulator and counters 0.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); pending memory transaction abandoned.
- All outputs registered. busy rises the cycle after go sampled.
- With mem_gnt tied 1 and mem_rvalid one cycle after grant: 5 cycles per k (RD_A, WT_A, RD_B, WT_B, MAC); per C element overhead COL + WR_C = 2 cycles, plus 2 in accum mode; ROW 1 cycle per row.
- aROWS==0 or bCOLS==0: no memory traffic; ret 3 or fewer cycles after go (IDLE, ROW/COL, DONE).
- mem_req/mem_addr/mem_write/mem_wdata must not change while mem_req=1 and mem_gnt=0.

## Test plan
- 2×2 unsigned, A=[[1,2],[3,4]], B=[[5,6],[7,8]], gnt=1, rvalid latency 1 → writes 19,22,43,50 to C in row order; one ret pulse; cycle count matches formula.
- signed_en=1, A=[[-3]], B=[[7]], aCOLS=1 → C = 0xFFFFFFEB; signed_en=0 same data → 0xFFFD·7 = 0x6FFEB.
- mode_accum=1, C preloaded 100, A=[[2]], B=[[3]] → C read then written 106; aCOLS=0 in accum mode → C rewritten 100.
- sat_en=1, signed, PREC=16, aCOLS=4, all A=B=0x7FFF → sum 0xFFFC0004 overflows 32-bit signed → written 0x7FFFFFFF; sat_en=0 → 0xFFFC0004.
- mode_bt=1 with B stored transposed, random mem_gnt (50%) and rvalid latency 1–5 → results equal golden model; request fields stable while ungranted.
- aROWS=0 → no mem_req, ret ≤3 cycles; rst_n low during WT_B then go restarts → mem_req=0 immediately, full correct result after restart.
